// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the serial add/sub unit
//
// Contents:
//   state_t  : control FSM states (IDLE, SHIFT, DONE)
//   OP_ADD   : sub_in encoding for A+B
//   OP_SUB   : sub_in encoding for A-B
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - combinational DIGIT-bit ripple adder
//
// Ports:
//   a        in  [DIGIT-1:0] addend digit
//   b        in  [DIGIT-1:0] addend digit (already inverted for subtract)
//   cin      in  1           carry into bit 0
//   sum      out [DIGIT-1:0] digit sum
//   cout     out 1           carry out of the top bit
//   c_msb_in out 1           carry into the top bit (for signed overflow)
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout     = carry[DIGIT];
    assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// rtl/serial_addsub_unit.sv - digit-serial adder/subtractor with valid/ready handshakes
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock (must divide WIDTH)
// Build option:
//   SERIAL_ADDSUB_SATURATE_EN  clamp y_out to the signed limit on overflow
//
// Ports:
//   clk        in  1       clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   valid_in   in  1       operand request valid
//   in_a       in  WIDTH   operand A
//   in_b       in  WIDTH   operand B
//   sub_in     in  1       0 = A+B, 1 = A-B (captured with operands)
//   ready_out  out 1       unit can accept operands this cycle
//   y_out      out WIDTH   result
//   carry_out  out 1       final carry (subtract: 1 = no borrow)
//   ovf_out    out 1       signed overflow
//   valid_out  out 1       result valid
//   ready_in   in  1       downstream accepts result
module serial_addsub_unit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             sub_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] y_out,
    output logic             carry_out,
    output logic             ovf_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub_unit: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_addsub_unit: DIGIT must evenly divide WIDTH");
    end

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] y_final;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_step;
    logic             ovf_now;

    logic [DIGIT-1:0] add_sum;
    logic             add_cout;
    logic             add_cmsb;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a        (a_reg[DIGIT-1:0]),
        .b        (b_reg[DIGIT-1:0]),
        .cin      (carry_reg),
        .sum      (add_sum),
        .cout     (add_cout),
        .c_msb_in (add_cmsb)
    );

    assign accept    = valid_in && ready_out;
    assign last_step = (state == SHIFT) && (cnt == LAST_STEP);

    // On the last step the adder is working on the MSB digit, so its carry
    // into the top bit and carry out are the word-level MSB carries.
    assign ovf_now = add_cmsb ^ add_cout;

    // New digit enters at the MSB side; after STEPS shifts the first digit
    // computed sits at bit 0.
    assign sh_next = WIDTH'({add_sum, sh_reg} >> DIGIT);

    always_comb begin
        y_final = sh_next;
`ifdef SERIAL_ADDSUB_SATURATE_EN
        // Overflow only happens when both effective MSBs agree, so A's MSB
        // alone tells the direction.
        if (ovf_now) begin
            if (a_reg[DIGIT-1]) begin
                y_final = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                y_final = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_next = accept ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_out = (state == IDLE) || ((state == DONE) && ready_in);
    end

    // Datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sh_reg    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            y_out     <= '0;
            carry_out <= 1'b0;
            ovf_out   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            if (accept) begin
                a_reg     <= in_a;
                b_reg     <= (sub_in == OP_SUB) ? ~in_b : in_b;
                carry_reg <= sub_in;
                cnt       <= '0;
            end else if (state == SHIFT) begin
                a_reg     <= a_reg >> DIGIT;
                b_reg     <= b_reg >> DIGIT;
                sh_reg    <= sh_next;
                carry_reg <= add_cout;
                cnt       <= cnt + CNT_W'(1);
            end

            if (last_step) begin
                y_out     <= y_final;
                carry_out <= add_cout;
                ovf_out   <= ovf_now;
            end

            valid_out <= (state_next == DONE);
        end
    end

endmodule
